jtkunio_obj_draw: RTL and testbench



---
 rtl/jtkunio_obj_draw.sv | 115 +++++++++++
 tb/tb_jtkunio_obj_draw.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkunio_obj_draw.sv
// Kunio object draw engine: fetches one 16-pixel 4bpp sprite row from the object ROM
// and writes its opaque pixels, one per clock, into the object line buffer.
module jtkunio_obj_draw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic [11:0] code,
  input  logic [3:0]  vsub,
  input  logic        hflip,
  input  logic [1:0]  pal,
  input  logic [7:0]  xpos,
  output logic        busy,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [7:0]  buf_addr,
  output logic [5:0]  buf_din,
  output logic        buf_we
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH0 = 3'd1;
  localparam logic [2:0] DRAW0  = 3'd2;
  localparam logic [2:0] FETCH1 = 3'd3;
  localparam logic [2:0] DRAW1  = 3'd4;

  logic [2:0]  st_q, st_d;
  logic [11:0] code_q;
  logic [3:0]  vsub_q;
  logic        hflip_q;
  logic [1:0]  pal_q;
  logic [7:0]  xpos_q;
  logic [31:0] word_q;
  logic [3:0]  cnt_q;
  logic        first_q;  // rom_ok may still belong to the previous address
  logic        capture;
  logic        drawing;
  logic [2:0]  idx;
  logic [31:0] shifted;
  logic [3:0]  pix;

  assign busy    = (st_q != IDLE);
  assign rom_cs  = (st_q == FETCH0) || (st_q == FETCH1);
  assign drawing = (st_q == DRAW0) || (st_q == DRAW1);

  always_comb begin
    st_d    = st_q;
    capture = 1'b0;
    case (st_q)
      IDLE:   if (draw) st_d = FETCH0;
      FETCH0: if (rom_ok && !first_q) begin
        capture = 1'b1;
        st_d    = DRAW0;
      end
      DRAW0:  if (cnt_q[2:0] == 3'd7) st_d = FETCH1;
      FETCH1: if (rom_ok && !first_q) begin
        capture = 1'b1;
        st_d    = DRAW1;
      end
      DRAW1:  if (cnt_q[2:0] == 3'd7) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Flipped rows walk the word right to left.
  always_comb begin
    idx     = hflip_q ? ~cnt_q[2:0] : cnt_q[2:0];
    shifted = word_q << {idx, 2'b00};
    pix     = shifted[31:28];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      code_q   <= '0;
      vsub_q   <= '0;
      hflip_q  <= 1'b0;
      pal_q    <= '0;
      xpos_q   <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      rom_addr <= '0;
      buf_addr <= '0;
      buf_din  <= '0;
      buf_we   <= 1'b0;
    end else begin
      st_q <= st_d;
      if (rom_cs) first_q <= 1'b0;
      if (st_q == IDLE && draw) begin
        code_q   <= code;
        vsub_q   <= vsub;
        hflip_q  <= hflip;
        pal_q    <= pal;
        xpos_q   <= xpos;
        cnt_q    <= '0;
        first_q  <= 1'b1;
        rom_addr <= {code, vsub, hflip, 1'b0};
      end
      if (st_q == DRAW0 && st_d == FETCH1) begin
        first_q  <= 1'b1;
        rom_addr <= {code_q, vsub_q, ~hflip_q, 1'b0};
      end
      if (capture) word_q <= rom_data;
      buf_we <= drawing && (pix != 4'd0);
      if (drawing) begin
        buf_addr <= xpos_q + {4'd0, cnt_q};
        buf_din  <= {pal_q, pix};
        cnt_q    <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_obj_draw.sv
// Randomized bench for jtkunio_obj_draw: a row-level model predicts ROM addresses,
// line-buffer writes and busy length; one negedge process compares the DUT against it.
module tb_jtkunio_obj_draw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw = 1'b0;
  logic [11:0] code = '0;
  logic [3:0]  vsub = '0;
  logic        hflip = 1'b0;
  logic [1:0]  pal = '0;
  logic [7:0]  xpos = '0;
  logic        busy, rom_cs, buf_we;
  logic [17:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [7:0]  buf_addr;
  logic [5:0]  buf_din;

  jtkunio_obj_draw dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .draw     (draw),
    .code     (code),
    .vsub     (vsub),
    .hflip    (hflip),
    .pal      (pal),
    .xpos     (xpos),
    .busy     (busy),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ROM contents and responder behaviour for the current request
  logic [31:0] words [2];
  int          extra [2];
  bit          stale = 1'b0;
  logic        req_hflip = 1'b0;
  int          fc = 0;

  // Model expectations
  logic [17:0] addr_q [$];
  logic [13:0] wr_q [$];
  int          busy_q [$];

  // Observations of the current request
  logic [17:0] obs_addr [$];
  logic [13:0] obs_wr [$];
  int          obs_busy = 0;

  logic [17:0] cur_addr = '0;
  bit          cs_prev = 1'b0;
  bit          busy_prev = 1'b0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Row-level reference: addresses, opaque writes and busy length of one request.
  task automatic push_expect(input logic [11:0] c, input logic [3:0] v, input logic h,
                             input logic [1:0] p, input logic [7:0] x);
    logic [31:0] w;
    logic        hw;
    int          k;
    logic [3:0]  px;
    addr_q.push_back({c, v, h, 1'b0});
    addr_q.push_back({c, v, ~h, 1'b0});
    for (int j = 0; j < 16; j++) begin
      hw = (j < 8) ? h : ~h;
      w  = words[hw];
      k  = h ? 7 - (j % 8) : j % 8;
      px = 4'((w >> (28 - 4 * k)) & 32'hF);
      if (px != 4'd0) wr_q.push_back({8'(int'(x) + j), p, px});
    end
    busy_q.push_back(20 + extra[0] + extra[1]);
  endtask

  // ROM responder: data valid from fetch cycle 2+extra; optional stale ok in cycle 1.
  always @(negedge clk) begin
    if (rom_cs) begin
      int  e;
      bit  valid;
      fc++;
      e = extra[int'(rom_addr[1] ^ req_hflip)];
      valid = (fc >= 2 + e);
      rom_ok = valid || (stale && fc == 1);
      rom_data = valid ? words[rom_addr[1]] : $urandom;
    end else begin
      fc = 0;
      rom_ok = 1'($urandom_range(0, 1));
      rom_data = $urandom;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_cs) begin
        if (!cs_prev) begin
          if (addr_q.size() == 0) fail("spurious_fetch", 32'(rom_addr));
          else cur_addr = addr_q.pop_front();
          obs_addr.push_back(rom_addr);
        end
        check("rom_addr", 32'(rom_addr), 32'(cur_addr));
      end
      cs_prev = rom_cs;
      if (buf_we) begin
        obs_wr.push_back({buf_addr, buf_din});
        if (wr_q.size() == 0) fail("spurious_write", 32'({buf_addr, buf_din}));
        else begin
          logic [13:0] e;
          e = wr_q.pop_front();
          check("buf_addr", 32'(buf_addr), 32'(e[13:6]));
          check("buf_din", 32'(buf_din), 32'(e[5:0]));
        end
      end
      if (busy) busy_cnt++;
      else if (busy_prev) begin
        if (busy_q.size() == 0) fail("spurious_busy", 32'(busy_cnt));
        else check("busy_len", 32'(busy_cnt), 32'(busy_q.pop_front()));
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("fetches_left", 32'(addr_q.size()), 32'd0);
        obs_busy = busy_cnt;
        busy_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic start_draw(input logic [11:0] c, input logic [3:0] v, input logic h,
                            input logic [1:0] p, input logic [7:0] x,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int e0, input int e1, input bit stl);
    check("idle_before_draw", 32'(busy), 32'd0);
    words[0] = w0;
    words[1] = w1;
    extra[0] = e0;
    extra[1] = e1;
    stale = stl;
    req_hflip = h;
    push_expect(c, v, h, p, x);
    obs_addr.delete();
    obs_wr.delete();
    code = c; vsub = v; hflip = h; pal = p; xpos = x;
    draw = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
    code = 12'($urandom); vsub = 4'($urandom); hflip = 1'($urandom);
    pal = 2'($urandom); xpos = 8'($urandom);
  endtask

  // mode 0: quiet, 1: random dropped draws, 2: draws at cycle 5 and in the last busy cycle
  task automatic finish_draw(input int mode);
    int cyc;
    int len;
    cyc = 0;
    len = 20 + extra[0] + extra[1];
    do begin
      @(negedge clk);
      cyc++;
      draw = 1'b0;
      if (busy && ((mode == 1 && $urandom_range(0, 3) == 0) ||
                   (mode == 2 && (cyc == 5 || cyc == len)))) begin
        draw = 1'b1;
        code = 12'($urandom); vsub = 4'($urandom); hflip = 1'($urandom);
        pal = 2'($urandom); xpos = 8'($urandom);
      end
    end while (busy && cyc < 300);
    draw = 1'b0;
    if (busy) fail("busy_timeout", 32'(cyc));
    #1;
  endtask

  initial begin
    words[0] = '0;
    words[1] = '0;
    extra[0] = 0;
    extra[1] = 0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    check("rst_buf_din", 32'(buf_din), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic draw
    start_draw(12'h123, 4'd5, 1'b0, 2'd2, 8'h10, 32'h12345678, 32'h9ABCDEF1, 0, 0, 1'b0);
    finish_draw(0);
    check("basic_addr0", 32'(obs_addr[0]), 32'h048D4);
    check("basic_addr1", 32'(obs_addr[1]), 32'h048D6);
    check("basic_nwr", 32'(obs_wr.size()), 32'd16);
    check("basic_wr0", 32'(obs_wr[0]), 32'({8'h10, 6'h21}));
    check("basic_wr15", 32'(obs_wr[15]), 32'({8'h1F, 6'h21}));
    check("basic_busy", 32'(obs_busy), 32'd20);

    // hflip, issued the cycle after busy is seen low
    start_draw(12'h123, 4'd5, 1'b1, 2'd2, 8'h10, 32'h12345678, 32'h9ABCDEF1, 0, 0, 1'b0);
    finish_draw(0);
    check("hflip_addr0", 32'(obs_addr[0]), 32'h048D6);
    check("hflip_wr0", 32'(obs_wr[0]), 32'({8'h10, 6'h21}));
    check("hflip_wr1", 32'(obs_wr[1]), 32'({8'h11, 6'h2F}));
    check("hflip_wr8", 32'(obs_wr[8]), 32'({8'h18, 6'h28}));

    // Transparency and wrap
    start_draw(12'h0A5, 4'd3, 1'b0, 2'd1, 8'hFC, 32'h00F000F0, 32'h0F0F0F0F, 0, 0, 1'b0);
    finish_draw(0);
    check("trans_nwr", 32'(obs_wr.size()), 32'd6);
    check("trans_wr0", 32'(obs_wr[0]), 32'({8'hFE, 6'h1F}));
    check("trans_wr1", 32'(obs_wr[1]), 32'({8'h02, 6'h1F}));
    check("trans_wr5", 32'(obs_wr[5]), 32'({8'h0B, 6'h1F}));

    // ROM stall in FETCH1
    start_draw(12'hFFF, 4'hF, 1'b0, 2'd3, 8'h80, 32'h87654321, 32'h11223344, 0, 7, 1'b0);
    finish_draw(0);
    check("stall_busy", 32'(obs_busy), 32'd27);

    // Stale rom_ok and dropped requests
    start_draw(12'h456, 4'd9, 1'b0, 2'd0, 8'h40, 32'hFEDCBA98, 32'h76543210, 0, 0, 1'b1);
    finish_draw(2);
    check("stale_wr0", 32'(obs_wr[0]), 32'({8'h40, 6'h0F}));
    check("stale_busy", 32'(obs_busy), 32'd20);

    // Randomized requests with dropped draws while busy
    for (int i = 0; i < 40; i++) begin
      start_draw(12'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
                 $urandom & 32'hF0F7FF3F, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom));
      finish_draw(1);
    end

    // Reset mid-draw
    start_draw(12'h321, 4'd2, 1'b0, 2'd1, 8'h20, 32'h12345678, 32'h9ABCDEF1, 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    check("we_before_reset", 32'(buf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_buf_we", 32'(buf_we), 32'd0);
    check("abort_rom_cs", 32'(rom_cs), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    addr_q.delete();
    wr_q.delete();
    busy_q.delete();
    cs_prev = 1'b0;
    busy_prev = 1'b0;
    busy_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'd0);
    end
    #1;

    start_draw(12'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
               $urandom, $urandom, 1, 2, 1'b0);
    finish_draw(1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
